axis_frame_arbiter: RTL and testbench

- Frame-granular round-robin arbiter/mux that shares one AXI-stream datapath (e.g. a downstream width adapter) between S_COUNT requesters.
- A grant is held from the first beat of a frame through its tlast beat, so frames are never interleaved.
- Output is registered through a two-entry skid stage, giving full throughput and no combinational path from output_axis_tready to input_axis_tready.

---
 rtl/axis_frame_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin AXI-stream arbiter/mux with a registered two-entry skid output.
// A grant is held from the first beat of a frame through its tlast beat.
module axis_frame_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic [S_COUNT-1:0]            input_axis_tvalid,
  output logic [S_COUNT-1:0]            input_axis_tready,
  input  logic [S_COUNT-1:0]            input_axis_tlast,
  input  logic [S_COUNT-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]         output_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         output_axis_tkeep,
  output logic                          output_axis_tvalid,
  input  logic                          output_axis_tready,
  output logic                          output_axis_tlast,
  output logic                          output_axis_tuser,
  output logic [SEL_WIDTH-1:0]          grant_index,
  output logic                          grant_valid
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_reg;
  logic [SEL_WIDTH-1:0]   grant_index_reg;
  logic [SEL_WIDTH-1:0]   last_grant_reg;
  logic                   grant_valid_reg;

  logic [DATA_WIDTH-1:0]  out_data_reg, temp_data_reg;
  logic [KEEP_WIDTH-1:0]  out_keep_reg, temp_keep_reg;
  logic                   out_last_reg, temp_last_reg;
  logic                   out_user_reg, temp_user_reg;
  logic                   out_valid_reg, temp_valid_reg;

  logic [DATA_WIDTH-1:0]  in_data [S_COUNT];
  logic [KEEP_WIDTH-1:0]  in_keep [S_COUNT];

  logic [DATA_WIDTH-1:0]  sel_data;
  logic [KEEP_WIDTH-1:0]  sel_keep;
  logic                   sel_valid, sel_last, sel_user;
  logic                   accept;

  logic                   arb_found;
  logic [SEL_WIDTH-1:0]   arb_index;
  logic [SEL_WIDTH-1:0]   arb_cand;
  int                     arb_pos;

  // Ready depends only on registered state, so downstream tready never reaches the inputs.
  generate
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_stream
      assign in_data[gi] = input_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_keep[gi] = input_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
      assign input_axis_tready[gi] = (state_reg == ACTIVE) &&
                                     (grant_index_reg == SEL_WIDTH'(gi)) &&
                                     !temp_valid_reg;
    end
  endgenerate

  assign sel_data  = in_data[grant_index_reg];
  assign sel_keep  = in_keep[grant_index_reg];
  assign sel_valid = input_axis_tvalid[grant_index_reg];
  assign sel_last  = input_axis_tlast[grant_index_reg];
  assign sel_user  = input_axis_tuser[grant_index_reg];
  assign accept    = (state_reg == ACTIVE) && sel_valid && !temp_valid_reg;

  // Scan farthest offset first so the nearest requester after last_grant wins.
  always_comb begin
    arb_found = 1'b0;
    arb_index = last_grant_reg;
    arb_cand  = '0;
    arb_pos   = 0;
    for (int k = S_COUNT; k >= 1; k--) begin
      arb_pos  = (int'(last_grant_reg) + k) % S_COUNT;
      arb_cand = SEL_WIDTH'(arb_pos);
      if (input_axis_tvalid[arb_cand]) begin
        arb_found = 1'b1;
        arb_index = arb_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      grant_index_reg <= '0;
      last_grant_reg  <= SEL_WIDTH'(S_COUNT-1);
      grant_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_found) begin
            state_reg       <= ACTIVE;
            grant_index_reg <= arb_index;
            last_grant_reg  <= arb_index;
            grant_valid_reg <= 1'b1;
          end
        end
        ACTIVE: begin
          if (accept && sel_last) begin
            state_reg       <= IDLE;
            grant_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_user_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      temp_data_reg  <= '0;
      temp_keep_reg  <= '0;
      temp_last_reg  <= 1'b0;
      temp_user_reg  <= 1'b0;
      temp_valid_reg <= 1'b0;
    end else if (accept) begin
      if (output_axis_tready || !out_valid_reg) begin
        out_data_reg  <= sel_data;
        out_keep_reg  <= sel_keep;
        out_last_reg  <= sel_last;
        out_user_reg  <= sel_user;
        out_valid_reg <= 1'b1;
      end else begin
        temp_data_reg  <= sel_data;
        temp_keep_reg  <= sel_keep;
        temp_last_reg  <= sel_last;
        temp_user_reg  <= sel_user;
        temp_valid_reg <= 1'b1;
      end
    end else if (output_axis_tready) begin
      // No accept is possible while temp is full, so draining temp never races a new beat.
      if (temp_valid_reg) begin
        out_data_reg   <= temp_data_reg;
        out_keep_reg   <= temp_keep_reg;
        out_last_reg   <= temp_last_reg;
        out_user_reg   <= temp_user_reg;
        out_valid_reg  <= 1'b1;
        temp_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign output_axis_tdata  = out_data_reg;
  assign output_axis_tkeep  = out_keep_reg;
  assign output_axis_tvalid = out_valid_reg;
  assign output_axis_tlast  = out_last_reg;
  assign output_axis_tuser  = out_user_reg;
  assign grant_index        = grant_index_reg;
  assign grant_valid        = grant_valid_reg;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter: per-stream frame sources, output monitor, one task per scenario.
module tb_axis_frame_arbiter;

  localparam int S  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [S*DW-1:0] input_axis_tdata  = '0;
  logic [S*KW-1:0] input_axis_tkeep  = '0;
  logic [S-1:0]    input_axis_tvalid = '0;
  logic [S-1:0]    input_axis_tready;
  logic [S-1:0]    input_axis_tlast  = '0;
  logic [S-1:0]    input_axis_tuser  = '0;
  logic [DW-1:0]   output_axis_tdata;
  logic [KW-1:0]   output_axis_tkeep;
  logic            output_axis_tvalid;
  logic            output_axis_tready;
  logic            output_axis_tlast;
  logic            output_axis_tuser;
  logic [SW-1:0]   grant_index;
  logic            grant_valid;

  int total = 0;
  int bad   = 0;

  beat_t       src_q [S][$];
  beat_t       exp_q [$];
  beat_t       obs_q [$];
  int          obs_cyc [$];
  int          exp_g [$];
  logic [SW-1:0] gnt_q [$];
  logic [S-1:0] hold = '0;
  logic        src_flush = 1'b0;
  logic        mon_en = 1'b1;
  logic [S-1:0] took;
  logic        gv_prev = 1'b0;
  int          cyc = 0;
  beat_t       src_b;

  axis_frame_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(input_axis_tdata), .input_axis_tkeep(input_axis_tkeep),
    .input_axis_tvalid(input_axis_tvalid), .input_axis_tready(input_axis_tready),
    .input_axis_tlast(input_axis_tlast), .input_axis_tuser(input_axis_tuser),
    .output_axis_tdata(output_axis_tdata), .output_axis_tkeep(output_axis_tkeep),
    .output_axis_tvalid(output_axis_tvalid), .output_axis_tready(output_axis_tready),
    .output_axis_tlast(output_axis_tlast), .output_axis_tuser(output_axis_tuser),
    .grant_index(grant_index), .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  // Frame sources: present queue heads at posedge+1, pop beats accepted at the previous edge.
  always begin
    @(negedge clk);
    for (int i = 0; i < S; i++) took[i] = rst && input_axis_tvalid[i] && input_axis_tready[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) begin
      if (src_flush) src_q[i].delete();
      else if (took[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (!src_flush && !hold[i] && src_q[i].size() > 0) begin
        src_b = src_q[i][0];
        input_axis_tdata[i*DW +: DW] = src_b.data;
        input_axis_tkeep[i*KW +: KW] = src_b.keep;
        input_axis_tlast[i] = src_b.last;
        input_axis_tuser[i] = src_b.user;
        input_axis_tvalid[i] = 1'b1;
      end else begin
        input_axis_tvalid[i] = 1'b0;
      end
    end
  end

  // Output monitor: record completed output beats and grant rising edges.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en && rst) begin
      if (output_axis_tvalid && output_axis_tready) begin
        obs_q.push_back({output_axis_tdata, output_axis_tkeep, output_axis_tlast, output_axis_tuser});
        obs_cyc.push_back(cyc);
      end
      if (grant_valid && !gv_prev) gnt_q.push_back(grant_index);
    end
    gv_prev = grant_valid;
  end

  function automatic logic [63:0] mk(int s, int f, int b);
    return {8'(s), 8'(f), 16'hC0DE, 32'(b)};
  endfunction

  task automatic push_frame(int s, int f, int n);
    for (int b = 0; b < n; b++) src_q[s].push_back({mk(s, f, b), 8'hFF, (b == n-1), 1'b0});
  endtask

  task automatic expect_frame(int s, int f, int n);
    for (int b = 0; b < n; b++) exp_q.push_back({mk(s, f, b), 8'hFF, (b == n-1), 1'b0});
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive_edge();
    rst = 1'b0;
    src_flush = 1'b1;
    repeat (2) drive_edge();
    rst = 1'b1;
    src_flush = 1'b0;
    obs_q.delete();
    obs_cyc.delete();
    gnt_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    output_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (output_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", output_axis_tvalid); end
    total++; if (output_axis_tdata !== '0) begin bad++; $display("FAIL rst_tdata: got %h want 0", output_axis_tdata); end
    total++; if (input_axis_tready !== '0) begin bad++; $display("FAIL rst_tready: got %b want 0000", input_axis_tready); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_grant_valid: got %b want 0", grant_valid); end
    total++; if (grant_index !== '0) begin bad++; $display("FAIL rst_grant_index: got %0d want 0", grant_index); end
    drive_edge();
    rst = 1'b1;
    output_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL idle_grant_valid: got %b want 0", grant_valid); end
    $display("test_reset checked");
  endtask

  task automatic test_two_streams();
    beat_t e, o;
    drive_edge();
    gnt_q.delete(); obs_q.delete(); obs_cyc.delete();
    push_frame(0, 1, 3); push_frame(2, 1, 3);
    expect_frame(0, 1, 3); expect_frame(2, 1, 3);
    exp_g = '{0, 2};
    for (int k = 0; k < 300 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL two_count: got %0d beats want 6", obs_q.size()); end
    if (obs_cyc.size() >= 4) begin
      total++; if (obs_cyc[1] - obs_cyc[0] != 1) begin bad++; $display("FAIL two_in_frame_gap: got %0d want 1", obs_cyc[1] - obs_cyc[0]); end
      total++; if (obs_cyc[3] - obs_cyc[2] != 2) begin bad++; $display("FAIL two_bubble_gap: got %0d want 2", obs_cyc[3] - obs_cyc[2]); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL two_beat: got %h want %h", o, e); end
      else $display("two_streams beat %h ok", o.data);
    end
    total++; if (gnt_q.size() != 2) begin bad++; $display("FAIL two_grants: got %0d grants want 2", gnt_q.size()); end
    for (int i = 0; i < 2 && i < gnt_q.size(); i++) begin
      total++; if (int'(gnt_q[i]) != exp_g[i]) begin bad++; $display("FAIL two_grant_seq[%0d]: got %0d want %0d", i, gnt_q[i], exp_g[i]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_round_robin();
    beat_t e, o;
    do_reset();
    exp_g.delete();
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < S; s++) begin
        push_frame(s, 10 + f, 1); expect_frame(s, 10 + f, 1); exp_g.push_back(s);
      end
    for (int k = 0; k < 300 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() != 8) begin bad++; $display("FAIL rr_count: got %0d beats want 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rr_beat: got %h want %h", o, e); end
      else $display("round_robin beat %h ok", o.data);
    end
    total++; if (gnt_q.size() != 8) begin bad++; $display("FAIL rr_grants: got %0d grants want 8", gnt_q.size()); end
    for (int i = 0; i < 8 && i < gnt_q.size(); i++) begin
      total++; if (int'(gnt_q[i]) != exp_g[i]) begin bad++; $display("FAIL rr_grant_seq[%0d]: got %0d want %0d", i, gnt_q[i], exp_g[i]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); gnt_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    int acc = 0;
    int k;
    drive_edge();
    push_frame(1, 4, 4); expect_frame(1, 4, 4);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (output_axis_tvalid && output_axis_tready) break;
    end
    total++; if (k >= 100) begin bad++; $display("FAIL bp_first_beat: got timeout want output beat"); end
    drive_edge();
    output_axis_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (input_axis_tvalid[1] && input_axis_tready[1]) acc++;
      if (c > 0) begin
        total++; if (input_axis_tready[1] !== 1'b0) begin bad++; $display("FAIL bp_tready_full[%0d]: got %b want 0", c, input_axis_tready[1]); end
        total++; if (output_axis_tvalid !== 1'b1) begin bad++; $display("FAIL bp_out_held[%0d]: got %b want 1", c, output_axis_tvalid); end
      end
    end
    total++; if (acc != 1) begin bad++; $display("FAIL bp_accepts_in_stall: got %0d want 1", acc); end
    drive_edge();
    output_axis_tready = 1'b1;
    for (int j = 0; j < 200 && obs_q.size() < exp_q.size(); j++) @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL bp_count: got %0d beats want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL bp_beat: got %h want %h", o, e); end
      else $display("backpressure beat %h ok", o.data);
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); gnt_q.delete();
  endtask

  task automatic test_hold_grant();
    beat_t e, o;
    int k;
    drive_edge();
    gnt_q.delete();
    push_frame(3, 5, 4); expect_frame(3, 5, 4);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (input_axis_tvalid[3] && input_axis_tready[3]) break;
    end
    total++; if (k >= 100) begin bad++; $display("FAIL hold_start: got timeout want stream 3 beat"); end
    drive_edge();
    hold[3] = 1'b1;
    push_frame(0, 5, 2); expect_frame(0, 5, 2);
    exp_g = '{3, 0};
    repeat (5) begin
      @(negedge clk);
      total++; if ({grant_valid, grant_index} !== 3'b111) begin bad++; $display("FAIL hold_grant: got valid=%b idx=%0d want valid=1 idx=3", grant_valid, grant_index); end
      total++; if (input_axis_tready[0] !== 1'b0) begin bad++; $display("FAIL hold_tready0: got %b want 0", input_axis_tready[0]); end
    end
    drive_edge();
    hold[3] = 1'b0;
    for (int j = 0; j < 200 && obs_q.size() < exp_q.size(); j++) @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL hold_count: got %0d beats want 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL hold_beat: got %h want %h", o, e); end
      else $display("hold_grant beat %h ok", o.data);
    end
    for (int i = 0; i < 2; i++) begin
      total++; if (i >= gnt_q.size() || int'(gnt_q[i]) != exp_g[i]) begin bad++; $display("FAIL hold_grant_seq[%0d]: got %0d want %0d", i, (i < gnt_q.size()) ? int'(gnt_q[i]) : -1, exp_g[i]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); gnt_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    beat_t e, o;
    int k;
    drive_edge();
    mon_en = 1'b0;
    push_frame(2, 6, 4);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (output_axis_tvalid && grant_valid && grant_index == 2) break;
    end
    total++; if (k >= 100) begin bad++; $display("FAIL midrst_start: got timeout want stream 2 active"); end
    drive_edge();
    rst = 1'b0;
    src_flush = 1'b1;
    #1;
    total++; if (output_axis_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_tvalid: got %b want 0", output_axis_tvalid); end
    total++; if (input_axis_tready !== '0) begin bad++; $display("FAIL midrst_tready: got %b want 0000", input_axis_tready); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL midrst_grant_valid: got %b want 0", grant_valid); end
    total++; if (grant_index !== '0) begin bad++; $display("FAIL midrst_grant_index: got %0d want 0", grant_index); end
    repeat (2) drive_edge();
    rst = 1'b1;
    src_flush = 1'b0;
    obs_q.delete(); obs_cyc.delete(); gnt_q.delete();
    mon_en = 1'b1;
    drive_edge();
    push_frame(3, 7, 1); push_frame(0, 7, 1);
    expect_frame(0, 7, 1); expect_frame(3, 7, 1);
    exp_g = '{0, 3};
    for (int j = 0; j < 200 && obs_q.size() < exp_q.size(); j++) @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL midrst_count: got %0d beats want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL midrst_beat: got %h want %h", o, e); end
      else $display("reset_mid_frame beat %h ok", o.data);
    end
    for (int i = 0; i < 2; i++) begin
      total++; if (i >= gnt_q.size() || int'(gnt_q[i]) != exp_g[i]) begin bad++; $display("FAIL midrst_grant_seq[%0d]: got %0d want %0d", i, (i < gnt_q.size()) ? int'(gnt_q[i]) : -1, exp_g[i]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); gnt_q.delete();
  endtask

  task automatic test_sideband();
    beat_t e, o;
    beat_t b0, b1;
    drive_edge();
    b0 = {mk(1, 8, 0), 8'hFF, 1'b0, 1'b0};
    b1 = {mk(1, 8, 1), 8'h0F, 1'b1, 1'b1};
    src_q[1].push_back(b0); src_q[1].push_back(b1);
    exp_q.push_back(b0); exp_q.push_back(b1);
    for (int j = 0; j < 200 && obs_q.size() < exp_q.size(); j++) @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL side_count: got %0d beats want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL side_beat: got keep=%h last=%b user=%b data=%h want keep=%h last=%b user=%b data=%h", o.keep, o.last, o.user, o.data, e.keep, e.last, e.user, e.data); end
      else $display("sideband beat %h keep=%h last=%b user=%b ok", o.data, o.keep, o.last, o.user);
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); gnt_q.delete();
  endtask

  initial begin
    test_reset();
    test_two_streams();
    test_round_robin();
    test_backpressure();
    test_hold_grant();
    test_reset_mid_frame();
    test_sideband();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
